conv_row_feeder: RTL
====================

CONV_ROW_FEEDER -- requirements
Module: conv_row_feeder

Interface
REQ-001 SHALL have parameter H, default 6: image rows per channel.
REQ-002 SHALL have parameter W, default 6: pixels per row, unpadded.
REQ-003 SHALL have parameter D, default 4: input channels.
REQ-004 SHALL have parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-005 SHALL have one clock and an asynchronous active-low reset.
- clk  in  1: clock, rising edge
- rstn_i  in  1: reset, asynchronous, active-low
REQ-006 SHALL have the following ports:
- frame_start_i  in  1: start frame load
- pix_i  in  DATA_WIDTH*W: one row of one channel; pixel j at bits [DATA_WIDTH*j +: DATA_WIDTH]
- pix_valid_i  in  1: pix_i valid
- pix_ready_o  out  1: row accepted when valid and ready are both high
- image0, image1, image2  out  DATA_WIDTH*(W+2) each: padded rows r-1, r, r+1
- image_start  out  1: window-issue pulse to the convolution engine
- conv_done_i  in  1: per-channel completion from the convolution engine
- add_done_i  in  1: row accumulation complete
- row_idx_o  out  $clog2(H): current output row r
- busy_o  out  1: high whenever state is not IDLE
- frame_done_o  out  1: one-cycle pulse at frame end

Function
REQ-007 SHALL implement the states IDLE, LOAD, ISSUE, WAIT_CONV, WAIT_ADD and DONE.
REQ-008 IDLE SHALL go to LOAD on frame_start_i; frame_start_i in any other state SHALL be ignored.
REQ-009 In LOAD, pix_ready_o SHALL be 1, and it SHALL be 0 in all other states.
REQ-010 In LOAD, beat n SHALL be stored as channel n/H, row n%H (channel-major order), and pix_valid_i low SHALL stall loading without loss.
REQ-011 On acceptance of beat D*H-1, the block SHALL go to ISSUE with r=0 and d=0.
REQ-012 Padded row layout SHALL be:
- slot 0 = 0
- slots 1..W = pixels 0..W-1
- slot W+1 = 0
- slot k at bits [DATA_WIDTH*k +: DATA_WIDTH]
REQ-013 image0/image1/image2 SHALL carry channel d, rows r-1/r/r+1; image0 SHALL be all-zero when r=0 and image2 SHALL be all-zero when r=H-1.
REQ-014 image rows SHALL be valid from the ISSUE cycle and held stable until the cycle after conv_done_i is accepted.
REQ-015 image_start SHALL be 1 for exactly the one ISSUE cycle, and ISSUE SHALL always go to WAIT_CONV.
REQ-016 In WAIT_CONV, on conv_done_i: if d<D-1, d SHALL be incremented and the next state SHALL be ISSUE; if d=D-1, the next state SHALL be WAIT_ADD.
REQ-017 In WAIT_ADD, on add_done_i: if r<H-1, r SHALL be incremented, d SHALL be cleared and the next state SHALL be ISSUE; if r=H-1, the next state SHALL be DONE.
REQ-018 An add_done_i coincident with the final conv_done_i (d=D-1) SHALL be latched, and WAIT_ADD SHALL then exit on its first cycle as if add_done_i were present.
REQ-019 conv_done_i and add_done_i outside REQ-016..018 SHALL be ignored and SHALL NOT be latched.
REQ-020 DONE SHALL assert frame_done_o for one cycle and then go to IDLE; the buffer contents SHALL be retained but unused.
REQ-021 Storage SHALL be D*H*W*DATA_WIDTH bits of registers, and row selection SHALL be combinational from (d, r) with registered outputs.
REQ-022 Issue latency SHALL be: the last accepted load beat leads to image_start exactly 1 cycle later; conv_done_i (d<D-1) leads to the next image_start 1 cycle later; add_done_i leads to the next image_start 1 cycle later.
REQ-023 Minimum frame time SHALL be D*H load cycles plus H*D*2 issue/wait cycles plus H add waits.

Reset
REQ-024 rstn_i low SHALL asynchronously force:
- state IDLE, d=0, r=0, load count 0, latched add_done 0
- pix_ready_o=0, image_start=0, busy_o=0, frame_done_o=0
- row_idx_o=0, image0/1/2=0
REQ-025 Reset asserted mid-frame SHALL abort the frame with no frame_done_o, and no image_start SHALL appear after rstn_i rises until a new frame_start_i plus a full load.
REQ-026 Buffer contents SHALL NOT require reset.

Verification
REQ-027 Scenario "nominal frame" (H=6, W=6, D=4): load 24 rows with pixel value = 16*ch+row, answer each image_start with conv_done_i 3 cycles later and add_done_i 5 cycles after the 4th conv_done_i. Required response: exactly 24 image_start pulses, row_idx_o stepping 0..5, then one frame_done_o.
REQ-028 Scenario "padding": at r=0, d=2, image0 SHALL be 0 and image1 SHALL be {0, 0x20 x6, 0}; at r=5, image2 SHALL be 0 and image0 slot 1 SHALL be 0x24.
REQ-029 Scenario "load backpressure": toggle pix_valid_i randomly during LOAD. Required response: stored data is identical to the contiguous case and the first image_start occurs 1 cycle after the 24th handshake.
REQ-030 Scenario "coincident done": assert add_done_i together with the final conv_done_i. Required response: the next image_start occurs 2 cycles later and r advances by 1.
REQ-031 Scenario "spurious inputs": conv_done_i in WAIT_ADD, add_done_i in WAIT_CONV with d<3, and frame_start_i in WAIT_CONV. Required response: no state, d or r change.
REQ-032 Scenario "reset mid-frame": assert rstn_i low during WAIT_CONV at r=3. Required response: all outputs 0 immediately, no frame_done_o, and a subsequent full frame passes REQ-027.

Source files
------------

// File: rtl/conv_row_feeder.sv
// conv_row_feeder: buffers a D x H x W frame and issues zero-padded 3-row windows
// per (channel, row) to a convolution engine, sequenced by its done handshakes.
module conv_row_feeder #(
    parameter int H = 6,
    parameter int W = 6,
    parameter int D = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rstn_i,
    input  logic                          frame_start_i,
    input  logic [DATA_WIDTH*W-1:0]       pix_i,
    input  logic                          pix_valid_i,
    output logic                          pix_ready_o,
    output logic [DATA_WIDTH*(W+2)-1:0]   image0,
    output logic [DATA_WIDTH*(W+2)-1:0]   image1,
    output logic [DATA_WIDTH*(W+2)-1:0]   image2,
    output logic                          image_start,
    input  logic                          conv_done_i,
    input  logic                          add_done_i,
    output logic [$clog2(H)-1:0]          row_idx_o,
    output logic                          busy_o,
    output logic                          frame_done_o
);
    localparam int RW = $clog2(H);
    localparam int DB = (D > 1) ? $clog2(D) : 1;
    localparam int PW = DATA_WIDTH*(W+2);
    localparam logic [RW-1:0] R_MAX = RW'(H-1);
    localparam logic [DB-1:0] D_MAX = DB'(D-1);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_CONV, WAIT_ADD, DONE} state_t;

    state_t                  state, nxt;
    logic [RW-1:0]           r, nr, lr;
    logic [DB-1:0]           d, nd, lc;
    logic                    add_lat, nlat, accept, last;
    logic [DATA_WIDTH*W-1:0] mem [D][H];
    logic [PW-1:0]           n_img0, n_img1, n_img2;

    // The final beat is still in flight when the first window is selected, so forward it.
    function automatic logic [PW-1:0] pad_row(input logic [DB-1:0] c, input logic [RW-1:0] rr);
        logic [DATA_WIDTH*W-1:0] px;
        px = (last && c == D_MAX && rr == R_MAX) ? pix_i : mem[c][rr];
        return {{DATA_WIDTH{1'b0}}, px, {DATA_WIDTH{1'b0}}};
    endfunction

    assign accept    = (state == LOAD) && pix_valid_i;
    assign last      = accept && lc == D_MAX && lr == R_MAX;
    assign row_idx_o = r;

    always_comb begin
        nxt  = state;
        nd   = d;
        nr   = r;
        nlat = add_lat;
        case (state)
            IDLE: nxt = frame_start_i ? LOAD : IDLE;
            LOAD: if (last) begin
                nxt  = ISSUE;
                nd   = '0;
                nr   = '0;
                nlat = 1'b0;
            end
            ISSUE: nxt = WAIT_CONV;
            WAIT_CONV: if (conv_done_i) begin
                if (d != D_MAX) begin
                    nd  = d + DB'(1);
                    nxt = ISSUE;
                end else begin
                    nxt  = WAIT_ADD;
                    nlat = add_done_i;
                end
            end
            WAIT_ADD: if (add_done_i || add_lat) begin
                nlat = 1'b0;
                if (r != R_MAX) begin
                    nr  = r + RW'(1);
                    nd  = '0;
                    nxt = ISSUE;
                end else begin
                    nxt = DONE;
                end
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        n_img0 = (nr == '0) ? '0 : pad_row(nd, nr - RW'(1));
        n_img1 = pad_row(nd, nr);
        n_img2 = (nr == R_MAX) ? '0 : pad_row(nd, nr + RW'(1));
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            d            <= '0;
            r            <= '0;
            lc           <= '0;
            lr           <= '0;
            add_lat      <= 1'b0;
            pix_ready_o  <= 1'b0;
            image_start  <= 1'b0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            image0       <= '0;
            image1       <= '0;
            image2       <= '0;
        end else begin
            state        <= nxt;
            d            <= nd;
            r            <= nr;
            add_lat      <= nlat;
            pix_ready_o  <= nxt == LOAD;
            image_start  <= nxt == ISSUE;
            busy_o       <= nxt != IDLE;
            frame_done_o <= nxt == DONE;
            if (state == IDLE) begin
                lc <= '0;
                lr <= '0;
            end else if (accept) begin
                lr <= (lr == R_MAX) ? '0 : lr + RW'(1);
                lc <= (lr == R_MAX) ? lc + DB'(1) : lc;
            end
            if (nxt == ISSUE) begin
                image0 <= n_img0;
                image1 <= n_img1;
                image2 <= n_img2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[lc][lr] <= pix_i;
    end
endmodule
